hazard_detection_unit: RTL

//   Stall/flush controller for the 5-stage pipeline; it acts on the register writer side of the datapath.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/hazard_detection_unit_if.sv | 38 +++
 rtl/hazard_detection_unit_wait_counter.sv | 29 ++
 rtl/hazard_detection_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants for the hazard detection unit.
// Imported by the hazard interface, the wait counter and the top.
package riscv_pkg;

  typedef enum logic [0:0] {
    HZ_RUN       = 1'b0,
    HZ_LOAD_WAIT = 1'b1
  } hz_state_t;

  localparam int          REG_W    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam int          WAIT_W   = 4;
  localparam int          LAT_MAX  = 15;

  // True when a writer in EX produces a register that an enabled DE source reads.
  function automatic logic src_match(
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs,
    input logic             used
  );
    return used && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// DE/EX hazard information into the hazard unit and pipeline enables/clears out of it.
// Perf counter widths follow CNT_W; they only carry data when HAZARD_PERF_EN is defined.
interface hazard_detection_unit_if #(
  parameter int CNT_W = 32
);
  import riscv_pkg::*;

  logic [REG_W-1:0] rs1_de;
  logic [REG_W-1:0] rs2_de;
  logic             rs1_used_de;
  logic             rs2_used_de;
  logic [REG_W-1:0] rd_ex;
  logic             RUWr_ex;
  logic             DMRd_ex;
  logic             NextPCSrc_ex;
  logic             Stall_pc;
  logic             Stall_de;
  logic             Flush_de;
  logic             Flush_ex;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  // Datapath side: supplies decode/execute fields, consumes enables and clears.
  modport master (
    output rs1_de, rs2_de, rs1_used_de, rs2_used_de,
    output rd_ex, RUWr_ex, DMRd_ex, NextPCSrc_ex,
    input  Stall_pc, Stall_de, Flush_de, Flush_ex,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  rs1_de, rs2_de, rs1_used_de, rs2_used_de,
    input  rd_ex, RUWr_ex, DMRd_ex, NextPCSrc_ex,
    output Stall_pc, Stall_de, Flush_de, Flush_ex,
    output stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_detection_unit_wait_counter.sv
// Loadable down-counter with zero flag that times the LOAD_WAIT extension of a load-use stall.
module hazard_wait_counter
  import riscv_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and branch flush controller for the 5-stage pipeline.
// Define HAZARD_PERF_EN to build the stall_cycles / flush_events performance counters.
module hazard_detection_unit
  import riscv_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_detection_unit_if.slave hz
);

  generate
    if (LOAD_LAT < 0 || LOAD_LAT > LAT_MAX) begin : g_lat_check
      $error("hazard_detection_unit: LOAD_LAT must be within 0..15");
    end
  endgenerate

  localparam bit                HAS_WAIT      = (LOAD_LAT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD_VAL = HAS_WAIT ? WAIT_W'(LOAD_LAT - 1) : '0;

  hz_state_t r_state;
  hz_state_t w_state_next;
  logic      w_lu_hit;
  logic      w_stall;
  logic      w_flush_br;
  logic      w_cnt_load;
  logic      w_cnt_dec;
  logic      w_wait_zero;

  assign w_lu_hit = hz.DMRd_ex && hz.RUWr_ex && (hz.rd_ex != REG_ZERO) &&
                    (src_match(hz.rd_ex, hz.rs1_de, hz.rs1_used_de) ||
                     src_match(hz.rd_ex, hz.rs2_de, hz.rs2_used_de));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HZ_RUN:       if (w_cnt_load)  w_state_next = HZ_LOAD_WAIT;
      HZ_LOAD_WAIT: if (w_wait_zero) w_state_next = HZ_RUN;
      default:      w_state_next = HZ_RUN;
    endcase
  end

  // A resolved branch squashes the DE instruction, so it overrides any load-use hit.
  always_comb begin
    w_stall    = 1'b0;
    w_flush_br = 1'b0;
    if (rst_n) begin
      case (r_state)
        HZ_RUN: begin
          if (hz.NextPCSrc_ex) begin
            w_flush_br = 1'b1;
          end else if (w_lu_hit) begin
            w_stall = 1'b1;
          end
        end
        HZ_LOAD_WAIT: w_stall = 1'b1;
        default: ;
      endcase
    end
  end

  assign hz.Stall_pc = w_stall;
  assign hz.Stall_de = w_stall;
  assign hz.Flush_de = w_flush_br;
  assign hz.Flush_ex = w_stall | w_flush_br;

  assign w_cnt_load = HAS_WAIT && w_stall && (r_state == HZ_RUN);
  assign w_cnt_dec  = (r_state == HZ_LOAD_WAIT);

  hazard_wait_counter #(
    .W (WAIT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_wait_zero)
  );

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall)    r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush_br) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign hz.stall_cycles = r_stall_cycles;
  assign hz.flush_events = r_flush_events;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_events = '0;
`endif

endmodule
